dispatch_stage: RTL and testbench
=================================

Name: dispatch_stage

Overview:
- Registered, parametrised successor to the combinational dispatcher; sits between decoder/regfile and the ALU RS, Branch RS and LS buffer.
- Owns tag allocation internally: one free bitmap per tag class.
- Renames rd in the accept cycle and snoops the CDB to bypass operands.
- Holds one instruction in an output register, with a valid/ready handshake per destination.

Parameters:
DATA_W, 32, operand/immediate width
ADDR_W, 32, instruction address width
NAME_W, 5, architectural register name width
OP_W, 6, opCode width
CLASS_W, 4, opClass width (encodings per defines.v Class* macros)
IDX_W, 4, tag index width; tag TAG_W = IDX_W+1 = {prefix, idx}
ALU_TAGS, 15, ALU tag count (must be <= 2^IDX_W-1)
LS_TAGS, 8, LS tag count (must be <= 2^IDX_W-1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  sync squash: clear held instruction, free all tags
in_valid  in  1  decoder has an instruction
in_ready  out  1  instruction accepted this cycle when in_valid&&in_ready
in_class  in  CLASS_W  opClass
in_op  in  OP_W  opCode
in_rd  in  NAME_W  destination name
in_imm  in  DATA_W  pre-selected immediate (I/U/J/S/B per class)
in_addr  in  ADDR_W  instruction address
rs1_tag / rs2_tag  in  TAG_W each  regfile tags (TAG_FREE = all-ones means ready)
rs1_data / rs2_data  in  DATA_W each  regfile data
wrt_en  out  1  rename write to regfile
wrt_tag  out  TAG_W  new tag for rd
wrt_name  out  NAME_W  rd name
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  DATA_W  broadcast data
alu_rel_en / alu_rel_idx  in  1 / IDX_W  return ALU tag to pool
ls_rel_en / ls_rel_idx  in  1 / IDX_W  return LS tag to pool
alu_valid / alu_ready  out / in  1 / 1  ALU RS handshake
br_valid / br_ready  out / in  1 / 1  Branch RS handshake
ls_valid / ls_ready  out / in  1 / 1  LS buffer handshake
out_op  out  OP_W  held opCode
out_addr  out  ADDR_W  held address
out_imm  out  DATA_W  held immediate
out_opnd1 / out_opnd2  out  DATA_W each  operand values
out_tag1 / out_tag2  out  TAG_W each  operand tags (TAG_FREE = value valid)
out_tagw  out  TAG_W  destination tag
out_namew  out  NAME_W  destination name

Behaviour:
- Reset (async, rst_n=0):
  - all out_*/valid signals 0, except tags = TAG_FREE.
  - Both bitmaps all free; held slot empty.
  - Reset mid-transfer drops the held instruction.
- Routing:
  - LUI/AUIPC/JAL/JALR/RI/RR -> ALU.
  - B -> Branch.
  - LD/ST -> LS.
  - Any other class: accepted, discarded, no tag allocated.
- Operand shaping matches the legacy dispatcher:
  - RI/LD/JALR/U/J classes: opnd2 = 0 with tag2 = TAG_FREE; in_imm goes to out_imm.
  - ST/B/RR: both sources used.
- Tag need: writer classes (ALU-routed, LD) with in_rd != 0.
  - LD draws from the LS pool with prefix 1; others from the ALU pool with prefix 0.
  - Lowest free index wins.
  - rd == 0: no allocation, wrt_en=0, out_tagw = TAG_FREE.
- in_ready = !flush && (slot empty || held target's ready) && (no tag need || pool has a free index).
- Accept cycle (combinational):
  - wrt_en=1 with allocated tag and rd.
  - Next edge: bitmap bit cleared and slot loaded.
  - Latency is 1 cycle: x_valid rises the cycle after acceptance.
- Hold: x_valid stays high with stable payload until x_ready; back-to-back acceptance is allowed on the handoff cycle.
- Release: alu_rel_en/ls_rel_en set the bit at the next edge.
  - A same-cycle release of index k is not visible to that cycle's allocation.
  - Release of an already-free index is ignored.
- flush: slot cleared, both bitmaps all free, wrt_en forced 0, in_ready=0 that cycle. flush overrides release and accept.
- Held operands also snoop the CDB every cycle (see optional feature).

Optional Feature:
DISPATCH_CDB_FWD_EN
- Defined:
  - At accept, a source whose regfile tag equals cdb_tag with cdb_valid is loaded as cdb_data with tag TAG_FREE.
  - While held, a matching out_tagN is replaced likewise at the next edge.
- Undefined: no bypass; regfile tag/data pass through unchanged.

Test Plan:
- Reset then RR (rd=3, rs tags free, data 5/7) -> wrt_en, wrt_tag=0x00; next cycle alu_valid, opnd 5/7, tagw=0x00.
- Accept 15 ALU writers with no release -> 16th has in_ready=0; alu_rel_idx=4 -> next accept gets tag 0x04.
- LD rd=9 -> tagw=0x10, ls_valid; ls_ready=0 for 3 cycles -> payload stable, in_ready=0; ls_ready=1 -> next instruction accepted same cycle.
- With DISPATCH_CDB_FWD_EN, held ST tag2=0x05 and CDB 0x05/0xDEAD -> next cycle opnd2=0xDEAD, tag2=TAG_FREE.
- rd=0 ADDI -> wrt_en=0, tagw=TAG_FREE, bitmap unchanged.
- Flush with held B and 6 tags allocated -> br_valid=0 next cycle; 15 ALU allocations succeed.

Source files
------------

// File: rtl/dispatch_stage_if.sv
// Signal bundle around dispatch_stage: decoder input, regfile rename, CDB, tag release and RS handshakes.
// master = dispatch_stage side, slave = surrounding pipeline.
interface dispatch_stage_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NAME_W  = 5,
    parameter int OP_W    = 6,
    parameter int CLASS_W = 4,
    parameter int IDX_W   = 4
);
    localparam int TAG_W = IDX_W + 1;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [CLASS_W-1:0] in_class;
    logic [OP_W-1:0]    in_op;
    logic [NAME_W-1:0]  in_rd;
    logic [DATA_W-1:0]  in_imm;
    logic [ADDR_W-1:0]  in_addr;
    logic [TAG_W-1:0]   rs1_tag;
    logic [TAG_W-1:0]   rs2_tag;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;
    logic               wrt_en;
    logic [TAG_W-1:0]   wrt_tag;
    logic [NAME_W-1:0]  wrt_name;
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic [DATA_W-1:0]  cdb_data;
    logic               alu_rel_en;
    logic [IDX_W-1:0]   alu_rel_idx;
    logic               ls_rel_en;
    logic [IDX_W-1:0]   ls_rel_idx;
    logic               alu_valid;
    logic               alu_ready;
    logic               br_valid;
    logic               br_ready;
    logic               ls_valid;
    logic               ls_ready;
    logic [OP_W-1:0]    out_op;
    logic [ADDR_W-1:0]  out_addr;
    logic [DATA_W-1:0]  out_imm;
    logic [DATA_W-1:0]  out_opnd1;
    logic [DATA_W-1:0]  out_opnd2;
    logic [TAG_W-1:0]   out_tag1;
    logic [TAG_W-1:0]   out_tag2;
    logic [TAG_W-1:0]   out_tagw;
    logic [NAME_W-1:0]  out_namew;

    modport master (
        input  flush, in_valid, in_class, in_op, in_rd, in_imm, in_addr,
               rs1_tag, rs2_tag, rs1_data, rs2_data,
               cdb_valid, cdb_tag, cdb_data,
               alu_rel_en, alu_rel_idx, ls_rel_en, ls_rel_idx,
               alu_ready, br_ready, ls_ready,
        output in_ready, wrt_en, wrt_tag, wrt_name,
               alu_valid, br_valid, ls_valid,
               out_op, out_addr, out_imm, out_opnd1, out_opnd2,
               out_tag1, out_tag2, out_tagw, out_namew
    );

    modport slave (
        output flush, in_valid, in_class, in_op, in_rd, in_imm, in_addr,
               rs1_tag, rs2_tag, rs1_data, rs2_data,
               cdb_valid, cdb_tag, cdb_data,
               alu_rel_en, alu_rel_idx, ls_rel_en, ls_rel_idx,
               alu_ready, br_ready, ls_ready,
        input  in_ready, wrt_en, wrt_tag, wrt_name,
               alu_valid, br_valid, ls_valid,
               out_op, out_addr, out_imm, out_opnd1, out_opnd2,
               out_tag1, out_tag2, out_tagw, out_namew
    );
endinterface

// File: rtl/dispatch_stage.sv
// Registered dispatch stage: routes by opClass, renames rd from per-class tag pools, holds one instruction.
// Optional CDB operand bypass (at accept and while held) is enabled by defining DISPATCH_CDB_FWD_EN.
module dispatch_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int NAME_W   = 5,
    parameter int OP_W     = 6,
    parameter int CLASS_W  = 4,
    parameter int IDX_W    = 4,
    parameter int ALU_TAGS = 15,
    parameter int LS_TAGS  = 8
) (
    input logic              clk,
    input logic              rst_n,
    dispatch_stage_if.master bus
);
    localparam int TAG_W  = IDX_W + 1;
    localparam int POOL_W = 1 << IDX_W;
    localparam logic [TAG_W-1:0] TAG_FREE = '1;

    localparam logic [CLASS_W-1:0] CLS_LUI   = CLASS_W'(0);
    localparam logic [CLASS_W-1:0] CLS_AUIPC = CLASS_W'(1);
    localparam logic [CLASS_W-1:0] CLS_JAL   = CLASS_W'(2);
    localparam logic [CLASS_W-1:0] CLS_JALR  = CLASS_W'(3);
    localparam logic [CLASS_W-1:0] CLS_B     = CLASS_W'(4);
    localparam logic [CLASS_W-1:0] CLS_LD    = CLASS_W'(5);
    localparam logic [CLASS_W-1:0] CLS_ST    = CLASS_W'(6);
    localparam logic [CLASS_W-1:0] CLS_RI    = CLASS_W'(7);
    localparam logic [CLASS_W-1:0] CLS_RR    = CLASS_W'(8);

    typedef enum logic [1:0] {S_EMPTY, S_ALU, S_BR, S_LS} state_e;

    function automatic logic [IDX_W-1:0] lowest_free(input logic [POOL_W-1:0] map);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = POOL_W - 1; i >= 0; i--) begin
            if (map[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   opnd1_q, opnd1_d;
    logic [DATA_W-1:0]   opnd2_q, opnd2_d;
    logic [TAG_W-1:0]    tag1_q, tag1_d;
    logic [TAG_W-1:0]    tag2_q, tag2_d;
    logic [TAG_W-1:0]    tagw_q, tagw_d;
    logic [NAME_W-1:0]   namew_q, namew_d;
    logic [ALU_TAGS-1:0] alu_free_q, alu_free_d;
    logic [LS_TAGS-1:0]  ls_free_q, ls_free_d;

    state_e              route;
    logic                imm_only;
    logic                writer;
    logic                need_tag;
    logic                ls_pool;
    logic                pool_avail;
    logic [IDX_W-1:0]    alloc_idx;
    logic [TAG_W-1:0]    new_tag;
    logic [POOL_W-1:0]   alu_map;
    logic [POOL_W-1:0]   ls_map;
    logic                held_ready;
    logic                ready_int;
    logic                accept;
    logic                load;
    logic                alloc;
    logic                fwd1, fwd2;
    logic                snoop1, snoop2;
    logic [DATA_W-1:0]   src1_data, src2_data;
    logic [TAG_W-1:0]    src1_tag, src2_tag;

    // Class decode: destination RS, whether the second operand is replaced by the immediate, and writers.
    always_comb begin
        route    = S_EMPTY;
        imm_only = 1'b0;
        writer   = 1'b0;
        case (bus.in_class)
            CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_RI: begin
                route    = S_ALU;
                imm_only = 1'b1;
                writer   = 1'b1;
            end
            CLS_RR: begin
                route  = S_ALU;
                writer = 1'b1;
            end
            CLS_B: route = S_BR;
            CLS_LD: begin
                route    = S_LS;
                imm_only = 1'b1;
                writer   = 1'b1;
            end
            CLS_ST: route = S_LS;
            default: route = S_EMPTY;
        endcase
    end

    assign ls_pool    = (bus.in_class == CLS_LD);
    assign need_tag   = writer && (bus.in_rd != '0);
    assign alu_map    = {{(POOL_W - ALU_TAGS){1'b0}}, alu_free_q};
    assign ls_map     = {{(POOL_W - LS_TAGS){1'b0}}, ls_free_q};
    assign pool_avail = ls_pool ? (|ls_free_q) : (|alu_free_q);
    assign alloc_idx  = ls_pool ? lowest_free(ls_map) : lowest_free(alu_map);
    assign new_tag    = {ls_pool, alloc_idx};

    always_comb begin
        held_ready = 1'b0;
        case (state_q)
            S_ALU:   held_ready = bus.alu_ready;
            S_BR:    held_ready = bus.br_ready;
            S_LS:    held_ready = bus.ls_ready;
            default: held_ready = 1'b0;
        endcase
    end

    assign ready_int = !bus.flush && ((state_q == S_EMPTY) || held_ready) && (!need_tag || pool_avail);
    assign accept    = bus.in_valid && ready_int;
    assign load      = accept && (route != S_EMPTY);
    assign alloc     = accept && need_tag;

`ifdef DISPATCH_CDB_FWD_EN
    assign fwd1   = bus.cdb_valid && (bus.rs1_tag != TAG_FREE) && (bus.rs1_tag == bus.cdb_tag);
    assign fwd2   = bus.cdb_valid && (bus.rs2_tag != TAG_FREE) && (bus.rs2_tag == bus.cdb_tag);
    assign snoop1 = (state_q != S_EMPTY) && bus.cdb_valid && (tag1_q != TAG_FREE) && (tag1_q == bus.cdb_tag);
    assign snoop2 = (state_q != S_EMPTY) && bus.cdb_valid && (tag2_q != TAG_FREE) && (tag2_q == bus.cdb_tag);
`else
    logic unused_cdb;
    assign unused_cdb = ^{bus.cdb_valid, bus.cdb_tag, bus.cdb_data};
    assign fwd1   = 1'b0;
    assign fwd2   = 1'b0;
    assign snoop1 = 1'b0;
    assign snoop2 = 1'b0;
`endif

    always_comb begin
        src1_data = fwd1 ? bus.cdb_data : bus.rs1_data;
        src1_tag  = fwd1 ? TAG_FREE : bus.rs1_tag;
        src2_data = fwd2 ? bus.cdb_data : bus.rs2_data;
        src2_tag  = fwd2 ? TAG_FREE : bus.rs2_tag;
        if (imm_only) begin
            src2_data = '0;
            src2_tag  = TAG_FREE;
        end
    end

    // Slot next-state: flush beats accept, accept beats handoff, held operands snoop otherwise.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        imm_d   = imm_q;
        opnd1_d = opnd1_q;
        opnd2_d = opnd2_q;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        tagw_d  = tagw_q;
        namew_d = namew_q;
        if (bus.flush) begin
            state_d = S_EMPTY;
            op_d    = '0;
            addr_d  = '0;
            imm_d   = '0;
            opnd1_d = '0;
            opnd2_d = '0;
            tag1_d  = TAG_FREE;
            tag2_d  = TAG_FREE;
            tagw_d  = TAG_FREE;
            namew_d = '0;
        end else if (load) begin
            state_d = route;
            op_d    = bus.in_op;
            addr_d  = bus.in_addr;
            imm_d   = bus.in_imm;
            opnd1_d = src1_data;
            opnd2_d = src2_data;
            tag1_d  = src1_tag;
            tag2_d  = src2_tag;
            tagw_d  = need_tag ? new_tag : TAG_FREE;
            namew_d = bus.in_rd;
        end else begin
            if (held_ready) state_d = S_EMPTY;
            if (snoop1) begin
                opnd1_d = bus.cdb_data;
                tag1_d  = TAG_FREE;
            end
            if (snoop2) begin
                opnd2_d = bus.cdb_data;
                tag2_d  = TAG_FREE;
            end
        end
    end

    // Release sets a bit, allocation clears one; allocation only ever sees the registered map.
    always_comb begin
        alu_free_d = alu_free_q;
        ls_free_d  = ls_free_q;
        if (bus.flush) begin
            alu_free_d = '1;
            ls_free_d  = '1;
        end else begin
            for (int i = 0; i < ALU_TAGS; i++) begin
                if (bus.alu_rel_en && (bus.alu_rel_idx == IDX_W'(i))) alu_free_d[i] = 1'b1;
                if (alloc && !ls_pool && (alloc_idx == IDX_W'(i)))    alu_free_d[i] = 1'b0;
            end
            for (int i = 0; i < LS_TAGS; i++) begin
                if (bus.ls_rel_en && (bus.ls_rel_idx == IDX_W'(i))) ls_free_d[i] = 1'b1;
                if (alloc && ls_pool && (alloc_idx == IDX_W'(i)))   ls_free_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            op_q       <= '0;
            addr_q     <= '0;
            imm_q      <= '0;
            opnd1_q    <= '0;
            opnd2_q    <= '0;
            tag1_q     <= TAG_FREE;
            tag2_q     <= TAG_FREE;
            tagw_q     <= TAG_FREE;
            namew_q    <= '0;
            alu_free_q <= '1;
            ls_free_q  <= '1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            imm_q      <= imm_d;
            opnd1_q    <= opnd1_d;
            opnd2_q    <= opnd2_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
            tagw_q     <= tagw_d;
            namew_q    <= namew_d;
            alu_free_q <= alu_free_d;
            ls_free_q  <= ls_free_d;
        end
    end

    assign bus.in_ready  = ready_int;
    assign bus.wrt_en    = alloc;
    assign bus.wrt_tag   = new_tag;
    assign bus.wrt_name  = bus.in_rd;
    assign bus.alu_valid = (state_q == S_ALU);
    assign bus.br_valid  = (state_q == S_BR);
    assign bus.ls_valid  = (state_q == S_LS);
    assign bus.out_op    = op_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_imm   = imm_q;
    assign bus.out_opnd1 = opnd1_q;
    assign bus.out_opnd2 = opnd2_q;
    assign bus.out_tag1  = tag1_q;
    assign bus.out_tag2  = tag2_q;
    assign bus.out_tagw  = tagw_q;
    assign bus.out_namew = namew_q;
endmodule

// File: tb/tb_dispatch_stage.sv
// Self-checking bench for dispatch_stage: routing/rename vector table plus hold, exhaustion, CDB and flush sequences.
`timescale 1ns/1ps
module tb_dispatch_stage;
    localparam int DATA_W = 32, ADDR_W = 32, NAME_W = 5, OP_W = 6, CLASS_W = 4, IDX_W = 4;
    localparam int ALU_TAGS = 15, LS_TAGS = 8;
    localparam logic [4:0] TF = 5'h1F;
    localparam logic [3:0] C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2, C_JALR = 4'd3, C_B = 4'd4;
    localparam logic [3:0] C_LD = 4'd5, C_ST = 4'd6, C_RI = 4'd7, C_RR = 4'd8, C_BAD = 4'd15;
    localparam logic [1:0] T_NONE = 2'd0, T_ALU = 2'd1, T_BR = 2'd2, T_LS = 2'd3;

    typedef struct {
        logic [3:0]  cls;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] addr;
        logic [4:0]  t1;
        logic [4:0]  t2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        rdy;
        logic        wen;
        logic [1:0]  tgt;
        logic [4:0]  tagw;
        logic [4:0]  tag1;
        logic [4:0]  tag2;
        logic [31:0] opnd1;
        logic [31:0] opnd2;
    } vec_t;

    typedef struct {
        logic [1:0]  tgt;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] imm;
        logic [31:0] opnd1;
        logic [31:0] opnd2;
        logic [4:0]  tag1;
        logic [4:0]  tag2;
        logic [4:0]  tagw;
        logic [4:0]  namew;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic [1:0] mon_got;
    exp_t tmp_e;
    vec_t vecs[12];
    logic fwd_on;

    dispatch_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NAME_W(NAME_W), .OP_W(OP_W),
                        .CLASS_W(CLASS_W), .IDX_W(IDX_W)) bus ();

    dispatch_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NAME_W(NAME_W), .OP_W(OP_W),
                     .CLASS_W(CLASS_W), .IDX_W(IDX_W), .ALU_TAGS(ALU_TAGS), .LS_TAGS(LS_TAGS))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] cls, input logic [5:0] op, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [31:0] addr,
                                input logic [4:0] t1, input logic [4:0] t2,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic rdy, input logic wen, input logic [1:0] tgt,
                                input logic [4:0] tagw, input logic [4:0] tag1, input logic [4:0] tag2,
                                input logic [31:0] opnd1, input logic [31:0] opnd2);
        vec_t v;
        v.cls = cls; v.op = op; v.rd = rd; v.imm = imm; v.addr = addr;
        v.t1 = t1; v.t2 = t2; v.d1 = d1; v.d2 = d2;
        v.rdy = rdy; v.wen = wen; v.tgt = tgt; v.tagw = tagw;
        v.tag1 = tag1; v.tag2 = tag2; v.opnd1 = opnd1; v.opnd2 = opnd2;
        return v;
    endfunction

    // Entered and left at posedge+1: present one instruction for one cycle and check the accept-cycle outputs.
    task automatic drive_check(input vec_t v);
        exp_t e;
        bus.in_class = v.cls; bus.in_op = v.op; bus.in_rd = v.rd; bus.in_imm = v.imm; bus.in_addr = v.addr;
        bus.rs1_tag = v.t1; bus.rs2_tag = v.t2; bus.rs1_data = v.d1; bus.rs2_data = v.d2;
        bus.in_valid = 1'b1;
        #1;
        chk("in_ready", bus.in_ready, v.rdy);
        chk("wrt_en", bus.wrt_en, v.wen);
        if (v.wen) begin
            chk("wrt_tag", bus.wrt_tag, v.tagw);
            chk("wrt_name", bus.wrt_name, v.rd);
        end
        if (v.rdy && v.tgt != T_NONE) begin
            e = '{v.tgt, v.op, v.addr, v.imm, v.opnd1, v.opnd2, v.tag1, v.tag2, v.tagw, v.rd};
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.cdb_valid = 1'b0;
        bus.alu_rel_en = 1'b0; bus.ls_rel_en = 1'b0;
        #1;
        chk("rst_alu_valid", bus.alu_valid, 1'b0);
        chk("rst_br_valid", bus.br_valid, 1'b0);
        chk("rst_ls_valid", bus.ls_valid, 1'b0);
        chk("rst_tagw", bus.out_tagw, TF);
        chk("rst_tag1", bus.out_tag1, TF);
        chk("rst_tag2", bus.out_tag2, TF);
        chk("rst_opnd1", bus.out_opnd1, 32'h0);
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Every completed handoff is matched against the oldest expected dispatch.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_got = T_NONE;
            if (bus.alu_valid && bus.alu_ready) mon_got = T_ALU;
            if (bus.br_valid && bus.br_ready)   mon_got = T_BR;
            if (bus.ls_valid && bus.ls_ready)   mon_got = T_LS;
            if (mon_got != T_NONE) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL handoff: unexpected transfer to target %0d, want none", mon_got);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("hand_tgt", mon_got, mon_e.tgt);
                    chk("hand_op", bus.out_op, mon_e.op);
                    chk("hand_addr", bus.out_addr, mon_e.addr);
                    chk("hand_imm", bus.out_imm, mon_e.imm);
                    chk("hand_opnd1", bus.out_opnd1, mon_e.opnd1);
                    chk("hand_opnd2", bus.out_opnd2, mon_e.opnd2);
                    chk("hand_tag1", bus.out_tag1, mon_e.tag1);
                    chk("hand_tag2", bus.out_tag2, mon_e.tag2);
                    chk("hand_tagw", bus.out_tagw, mon_e.tagw);
                    chk("hand_namew", bus.out_namew, mon_e.namew);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
`ifdef DISPATCH_CDB_FWD_EN
        fwd_on = 1'b1;
`else
        fwd_on = 1'b0;
`endif
        rst_n = 1'b0;
        bus.flush = 0; bus.in_valid = 0; bus.in_class = 0; bus.in_op = 0; bus.in_rd = 0;
        bus.in_imm = 0; bus.in_addr = 0; bus.rs1_tag = TF; bus.rs2_tag = TF;
        bus.rs1_data = 0; bus.rs2_data = 0; bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        bus.alu_rel_en = 0; bus.alu_rel_idx = 0; bus.ls_rel_en = 0; bus.ls_rel_idx = 0;
        bus.alu_ready = 1; bus.br_ready = 1; bus.ls_ready = 1;
        @(posedge clk); #1;
        do_reset();

        // cls op rd imm addr | t1 t2 d1 d2 | rdy wen tgt tagw tag1 tag2 opnd1 opnd2
        vecs[0]  = mk(C_RR,    6'h01, 5'd3, 32'h0,        32'h100, TF, TF, 32'd5, 32'd7,
                      1, 1, T_ALU, 5'h00, TF, TF, 32'd5, 32'd7);
        vecs[1]  = mk(C_RI,    6'h02, 5'd4, 32'h123,      32'h104, TF, 5'h02, 32'd9, 32'hAAAA,
                      1, 1, T_ALU, 5'h01, TF, TF, 32'd9, 32'd0);
        vecs[2]  = mk(C_LD,    6'h03, 5'd9, 32'h40,       32'h108, 5'h01, TF, 32'h1000, 32'h77,
                      1, 1, T_LS, 5'h10, 5'h01, TF, 32'h1000, 32'd0);
        vecs[3]  = mk(C_ST,    6'h04, 5'd0, 32'h8,        32'h10C, TF, 5'h03, 32'h2000, 32'h55,
                      1, 0, T_LS, TF, TF, 5'h03, 32'h2000, 32'h55);
        vecs[4]  = mk(C_B,     6'h05, 5'd0, 32'h20,       32'h110, 5'h01, TF, 32'd1, 32'd2,
                      1, 0, T_BR, TF, 5'h01, TF, 32'd1, 32'd2);
        vecs[5]  = mk(C_RI,    6'h13, 5'd0, 32'h1,        32'h114, TF, TF, 32'd3, 32'd4,
                      1, 0, T_ALU, TF, TF, TF, 32'd3, 32'd0);
        vecs[6]  = mk(C_LUI,   6'h37, 5'd5, 32'h12345000, 32'h118, TF, TF, 32'd0, 32'd0,
                      1, 1, T_ALU, 5'h02, TF, TF, 32'd0, 32'd0);
        vecs[7]  = mk(C_JAL,   6'h6F, 5'd1, 32'h8,        32'h11C, TF, TF, 32'd0, 32'd0,
                      1, 1, T_ALU, 5'h03, TF, TF, 32'd0, 32'd0);
        vecs[8]  = mk(C_JALR,  6'h67, 5'd1, 32'h4,        32'h120, TF, TF, 32'h300, 32'h9,
                      1, 1, T_ALU, 5'h04, TF, TF, 32'h300, 32'd0);
        vecs[9]  = mk(C_AUIPC, 6'h17, 5'd2, 32'h1000,     32'h124, TF, TF, 32'd0, 32'd0,
                      1, 1, T_ALU, 5'h05, TF, TF, 32'd0, 32'd0);
        vecs[10] = mk(C_BAD,   6'h3F, 5'd6, 32'h0,        32'h128, TF, TF, 32'd0, 32'd0,
                      1, 0, T_NONE, TF, TF, TF, 32'd0, 32'd0);
        vecs[11] = mk(C_LD,    6'h03, 5'd7, 32'h4,        32'h12C, TF, TF, 32'h50, 32'd0,
                      1, 1, T_LS, 5'h11, TF, TF, 32'h50, 32'd0);
        for (int i = 0; i < 12; i++) drive_check(vecs[i]);
        repeat (2) @(posedge clk); #1;
        chk("table_drain", sbq.size(), 0);

        // ALU pool exhaustion, then a release is visible only to the following cycle.
        do_reset();
        for (int i = 0; i < 15; i++)
            drive_check(mk(C_RR, 6'h01, 5'(i + 1), 32'h0, 32'h200 + 32'(i), TF, TF, 32'(i), 32'd1,
                           1, 1, T_ALU, 5'(i), TF, TF, 32'(i), 32'd1));
        bus.alu_rel_en = 1'b1; bus.alu_rel_idx = 4'd4;
        drive_check(mk(C_RR, 6'h01, 5'd16, 32'h0, 32'h300, TF, TF, 32'd0, 32'd0,
                       0, 0, T_ALU, TF, TF, TF, 32'd0, 32'd0));
        bus.alu_rel_en = 1'b0;
        drive_check(mk(C_RR, 6'h01, 5'd17, 32'h0, 32'h304, TF, TF, 32'd8, 32'd9,
                       1, 1, T_ALU, 5'h04, TF, TF, 32'd8, 32'd9));
        repeat (2) @(posedge clk); #1;

        // LS hold: stable payload and blocked input while ls_ready is low, same-cycle handoff after.
        do_reset();
        bus.ls_ready = 1'b0;
        drive_check(mk(C_LD, 6'h03, 5'd9, 32'h10, 32'h400, 5'h02, TF, 32'hABC, 32'd0,
                       1, 1, T_LS, 5'h10, 5'h02, TF, 32'hABC, 32'd0));
        for (int k = 0; k < 3; k++) begin
            chk("hold_ls_valid", bus.ls_valid, 1'b1);
            chk("hold_tagw", bus.out_tagw, 5'h10);
            chk("hold_namew", bus.out_namew, 5'd9);
            chk("hold_opnd1", bus.out_opnd1, 32'hABC);
            drive_check(mk(C_RR, 6'h01, 5'd2, 32'h0, 32'h404, TF, TF, 32'd1, 32'd2,
                           0, 0, T_ALU, TF, TF, TF, 32'd1, 32'd2));
        end
        bus.ls_ready = 1'b1;
        drive_check(mk(C_RR, 6'h01, 5'd2, 32'h0, 32'h404, TF, TF, 32'd1, 32'd2,
                       1, 1, T_ALU, 5'h00, TF, TF, 32'd1, 32'd2));
        repeat (2) @(posedge clk); #1;

        // CDB snoop of a held store, then bypass at accept.
        do_reset();
        bus.ls_ready = 1'b0;
        drive_check(mk(C_ST, 6'h04, 5'd0, 32'h0, 32'h500, TF, 5'h05, 32'h3000, 32'h1111,
                       1, 0, T_LS, TF, TF, 5'h05, 32'h3000, 32'h1111));
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'h05; bus.cdb_data = 32'hDEAD;
        @(posedge clk); #1;
        bus.cdb_valid = 1'b0;
        chk("snoop_opnd2", bus.out_opnd2, fwd_on ? 32'hDEAD : 32'h1111);
        chk("snoop_tag2", bus.out_tag2, fwd_on ? TF : 5'h05);
        tmp_e = sbq[0];
        tmp_e.opnd2 = fwd_on ? 32'hDEAD : 32'h1111;
        tmp_e.tag2  = fwd_on ? TF : 5'h05;
        sbq[0] = tmp_e;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'h06; bus.cdb_data = 32'hBEEF;
        bus.ls_ready = 1'b1;
        drive_check(mk(C_RR, 6'h01, 5'd8, 32'h0, 32'h504, 5'h06, TF, 32'd1, 32'd2,
                       1, 1, T_ALU, 5'h00, fwd_on ? TF : 5'h06, TF, fwd_on ? 32'hBEEF : 32'd1, 32'd2));
        bus.cdb_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Flush squashes a held branch and returns all tags.
        do_reset();
        bus.br_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            drive_check(mk(C_RR, 6'h01, 5'(i + 1), 32'h0, 32'h600 + 32'(i), TF, TF, 32'd0, 32'd0,
                           1, 1, T_ALU, 5'(i), TF, TF, 32'd0, 32'd0));
        drive_check(mk(C_B, 6'h05, 5'd0, 32'h40, 32'h620, TF, TF, 32'd3, 32'd4,
                       1, 0, T_BR, TF, TF, TF, 32'd3, 32'd4));
        chk("flush_pre_br_valid", bus.br_valid, 1'b1);
        bus.flush = 1'b1;
        drive_check(mk(C_RR, 6'h01, 5'd7, 32'h0, 32'h624, TF, TF, 32'd0, 32'd0,
                       0, 0, T_ALU, TF, TF, TF, 32'd0, 32'd0));
        bus.flush = 1'b0;
        if (sbq.size() > 0) void'(sbq.pop_back());
        chk("flush_br_valid", bus.br_valid, 1'b0);
        chk("flush_tagw", bus.out_tagw, TF);
        bus.br_ready = 1'b1;
        for (int i = 0; i < 15; i++)
            drive_check(mk(C_RR, 6'h01, 5'(i + 1), 32'h0, 32'h700 + 32'(i), TF, TF, 32'd0, 32'd0,
                           1, 1, T_ALU, 5'(i), TF, TF, 32'd0, 32'd0));
        repeat (3) @(posedge clk); #1;
        chk("final_drain", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
